// File: rtl/mprj_io_pattern_seq.sv
// Wishbone-programmable pattern sequencer for user IO pads.
// Steps through a (data, hold) table and drives each value for hold+1 clocks.
module mprj_io_pattern_seq #(
  parameter logic [31:0] BASE_ADR = 32'h3000_1000,
  parameter int          NPINS    = 8,
  parameter int          DEPTH    = 16,
  parameter int          HOLD_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [NPINS-1:0] io_out,
  output logic [NPINS-1:0] io_oeb,
  output logic             seq_busy,
  output logic             seq_done
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [NPINS-1:0]    io_out_q, io_out_d;
  logic [NPINS-1:0]    oeb_q, oeb_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                loop_q, loop_d;
  logic [IW-1:0]       last_q, last_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_o_q, dat_o_d;
  logic [NPINS-1:0]    ent_data_q [DEPTH];
  logic [NPINS-1:0]    ent_data_d [DEPTH];
  logic [HOLD_W-1:0]   ent_hold_q [DEPTH];
  logic [HOLD_W-1:0]   ent_hold_d [DEPTH];

  logic [7:0]    off;
  logic          blk_hit, access, wr, rd;
  logic          ctrl_hit, status_hit, oeb_hit, entry_hit;
  logic [IW-1:0] widx, nxt_idx;
  logic          start, stop;
  logic [31:0]   wr_word;
  logic          unused_ok;

  // The ack flop gates new accesses, so every access takes two clocks.
  assign off        = wbs_adr_i[7:0];
  assign blk_hit    = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign access     = wbs_stb_i & wbs_cyc_i & blk_hit & ~ack_q;
  assign wr         = access & wbs_we_i;
  assign rd         = access & ~wbs_we_i;
  assign ctrl_hit   = (off[7:2] == 6'h00);
  assign status_hit = (off[7:2] == 6'h01);
  assign oeb_hit    = (off[7:2] == 6'h02);
  assign entry_hit  = off[7] && ({1'b0, off[6:2]} < 6'(DEPTH));
  assign widx       = off[2 +: IW];
  assign nxt_idx    = idx_q + 1'b1;
  assign start      = wr & ctrl_hit & wbs_sel_i[0] & wbs_dat_i[0];
  assign stop       = wr & ctrl_hit & wbs_sel_i[0] & wbs_dat_i[1];
  assign unused_ok  = ^{wr_word, wbs_adr_i[1:0], wbs_dat_i};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    io_out_d   = io_out_q;
    oeb_d      = oeb_q;
    busy_d     = busy_q;
    done_d     = done_q;
    loop_d     = loop_q;
    last_d     = last_q;
    ack_d      = access;
    dat_o_d    = '0;
    ent_data_d = ent_data_q;
    ent_hold_d = ent_hold_q;
    wr_word    = 32'(ent_data_q[widx]) | (32'(ent_hold_q[widx]) << 16);

    if (wr && ctrl_hit && wbs_sel_i[0]) begin
      loop_d = wbs_dat_i[2];
      last_d = wbs_dat_i[4 +: IW];
    end
    if (wr && oeb_hit && wbs_sel_i[0]) begin
      oeb_d = wbs_dat_i[NPINS-1:0];
    end
    // Byte-lane merge keeps unselected lanes of the entry word intact.
    if (wr && entry_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) wr_word[8*b +: 8] = wbs_dat_i[8*b +: 8];
      end
      ent_data_d[widx] = wr_word[NPINS-1:0];
      ent_hold_d[widx] = wr_word[16 +: HOLD_W];
    end

    if (rd) begin
      if (status_hit) begin
        dat_o_d = {20'h0, 4'(idx_q), 4'(last_q), 1'b0, loop_q, done_q, busy_q};
      end else if (oeb_hit) begin
        dat_o_d = 32'(oeb_q);
      end else if (entry_hit) begin
        dat_o_d = 32'(ent_data_q[widx]) | (32'(ent_hold_q[widx]) << 16);
      end
    end

    // STOP outranks START; a step-end loads the next entry on the same edge.
    if (stop) begin
      if (state_q == RUN) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    end else if (start) begin
      state_d  = RUN;
      idx_d    = '0;
      io_out_d = ent_data_q[0];
      cnt_d    = ent_hold_q[0];
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end else if (state_q == RUN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (idx_q != last_q) begin
        idx_d    = nxt_idx;
        io_out_d = ent_data_q[nxt_idx];
        cnt_d    = ent_hold_q[nxt_idx];
      end else if (loop_q) begin
        idx_d    = '0;
        io_out_d = ent_data_q[0];
        cnt_d    = ent_hold_q[0];
      end else begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      io_out_q <= '0;
      oeb_q    <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      loop_q   <= 1'b0;
      last_q   <= IW'(DEPTH - 1);
      ack_q    <= 1'b0;
      dat_o_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_data_q[i] <= '0;
        ent_hold_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      io_out_q   <= io_out_d;
      oeb_q      <= oeb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      loop_q     <= loop_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      dat_o_q    <= dat_o_d;
      ent_data_q <= ent_data_d;
      ent_hold_q <= ent_hold_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_o_q;
  assign io_out    = io_out_q;
  assign io_oeb    = oeb_q;
  assign seq_busy  = busy_q;
  assign seq_done  = done_q;

endmodule
